dispatch_unit: RTL and testbench

- Sits between rename and the three reservation stations (ALU, branch, memory).
- Buffers renamed instructions in a small FIFO and allocates ROB indices in order.
- Owns the physical-register ready table and resolves pr1_ready/pr2_ready at dispatch, with a same-cycle bypass from the CDB ready broadcasts.
- Routes each instruction by opcode to exactly one RS and marks its destination register not-ready.

---
 rtl/dispatch_unit_if.sv | 66 ++++++
 rtl/dispatch_unit.sv | 171 +++++++++++++++++
 tb/tb_dispatch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_unit_if.sv
// Shared payload type and the rename/RS-facing bundle of the dispatch unit.
// The dispatch unit takes the slave side; rename, the RSs and the ROB drive the master side.
package dispatch_unit_pkg;
  typedef struct packed {
    logic [6:0]  prd;
    logic [6:0]  pr1;
    logic [6:0]  pr2;
    logic        pr1_ready;
    logic        pr2_ready;
    logic [31:0] imm;
    logic [3:0]  rob_index;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
  } dispatch_pipeline_data;
endpackage

interface dispatch_unit_if;
  import dispatch_unit_pkg::*;

  logic        valid_in;
  logic        ready_in;
  logic [6:0]  in_prd;
  logic [6:0]  in_pr1;
  logic [6:0]  in_pr2;
  logic        in_has_rd;
  logic        in_uses_rs1;
  logic        in_uses_rs2;
  logic [31:0] in_imm;
  logic [6:0]  in_opcode;
  logic [2:0]  in_func3;
  logic [6:0]  in_func7;
  logic        rob_ready;
  logic        rob_alloc;
  logic [3:0]  rob_flush_tail;
  logic        alu_valid;
  logic        alu_ready;
  logic        br_valid;
  logic        br_ready;
  logic        mem_valid;
  logic        mem_ready;
  dispatch_pipeline_data dispatch_out;
  logic [6:0]  reg1_rdy;
  logic [6:0]  reg2_rdy;
  logic [6:0]  reg3_rdy;
  logic        reg1_rdy_valid;
  logic        reg2_rdy_valid;
  logic        reg3_rdy_valid;
  logic        flush;

  modport slave (
    input  valid_in, in_prd, in_pr1, in_pr2, in_has_rd, in_uses_rs1, in_uses_rs2,
           in_imm, in_opcode, in_func3, in_func7, rob_ready, rob_flush_tail,
           alu_ready, br_ready, mem_ready, reg1_rdy, reg2_rdy, reg3_rdy,
           reg1_rdy_valid, reg2_rdy_valid, reg3_rdy_valid, flush,
    output ready_in, rob_alloc, alu_valid, br_valid, mem_valid, dispatch_out
  );

  modport master (
    output valid_in, in_prd, in_pr1, in_pr2, in_has_rd, in_uses_rs1, in_uses_rs2,
           in_imm, in_opcode, in_func3, in_func7, rob_ready, rob_flush_tail,
           alu_ready, br_ready, mem_ready, reg1_rdy, reg2_rdy, reg3_rdy,
           reg1_rdy_valid, reg2_rdy_valid, reg3_rdy_valid, flush,
    input  ready_in, rob_alloc, alu_valid, br_valid, mem_valid, dispatch_out
  );
endinterface

// File: rtl/dispatch_unit.sv
// In-order dispatch: small instruction FIFO, ROB tail allocation, physical-register
// ready table with CDB bypass, and opcode routing to the ALU/branch/memory RSs.
module dispatch_unit
  import dispatch_unit_pkg::*;
#(
  parameter int PREGS      = 128,
  parameter int ROB_DEPTH  = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  dispatch_unit_if.slave disp
);

  localparam int PW = $clog2(PREGS);
  localparam int RW = $clog2(ROB_DEPTH);
  localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [PW-1:0] prd;
    logic [PW-1:0] pr1;
    logic [PW-1:0] pr2;
    logic          has_rd;
    logic          uses_rs1;
    logic          uses_rs2;
    logic [31:0]   imm;
    logic [6:0]    opcode;
    logic [2:0]    func3;
    logic [6:0]    func7;
  } entry_t;

  entry_t        fifo_q [FIFO_DEPTH];
  entry_t        head;
  entry_t        entry_in;
  logic [FW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] rob_tail_q, rob_tail_d;
  logic [PREGS-1:0] rdy_q, rdy_d;
  logic          ready_in_q;

  logic          nonempty, can_go, enq, fire;
  logic          is_mem, is_br;
  logic [PW-1:0] bc_reg [3];
  logic [2:0]    bc_vld;
  logic [2:0]    hit1, hit2;
  logic          pr1_ready, pr2_ready;
  dispatch_pipeline_data out_d;

  function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
    return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + FW'(1);
  endfunction

  assign entry_in = '{
    prd:      disp.in_prd,
    pr1:      disp.in_pr1,
    pr2:      disp.in_pr2,
    has_rd:   disp.in_has_rd,
    uses_rs1: disp.in_uses_rs1,
    uses_rs2: disp.in_uses_rs2,
    imm:      disp.in_imm,
    opcode:   disp.in_opcode,
    func3:    disp.in_func3,
    func7:    disp.in_func7
  };

  assign head     = fifo_q[head_q];
  assign nonempty = (count_q != '0);
  assign enq      = disp.valid_in && ready_in_q && !disp.flush;

  assign is_mem = (head.opcode == 7'h03) || (head.opcode == 7'h23);
  assign is_br  = (head.opcode == 7'h63) || (head.opcode == 7'h6F) || (head.opcode == 7'h67);

  // Flush and reset both gate dispatch so nothing fires in a squashed cycle.
  assign can_go         = reset && nonempty && disp.rob_ready && !disp.flush;
  assign disp.mem_valid = can_go && is_mem;
  assign disp.br_valid  = can_go && is_br;
  assign disp.alu_valid = can_go && !is_mem && !is_br;
  assign fire = (disp.mem_valid && disp.mem_ready) ||
                (disp.br_valid  && disp.br_ready)  ||
                (disp.alu_valid && disp.alu_ready);
  assign disp.rob_alloc = fire;
  assign disp.ready_in  = reset && ready_in_q;

  assign bc_reg[0] = disp.reg1_rdy;
  assign bc_reg[1] = disp.reg2_rdy;
  assign bc_reg[2] = disp.reg3_rdy;
  assign bc_vld    = {disp.reg3_rdy_valid, disp.reg2_rdy_valid, disp.reg1_rdy_valid};

  for (genvar gi = 0; gi < 3; gi++) begin : g_bypass
    assign hit1[gi] = bc_vld[gi] && (bc_reg[gi] == head.pr1);
    assign hit2[gi] = bc_vld[gi] && (bc_reg[gi] == head.pr2);
  end

  assign pr1_ready = !head.uses_rs1 || (head.pr1 == '0) || rdy_q[head.pr1] || (|hit1);
  assign pr2_ready = !head.uses_rs2 || (head.pr2 == '0) || rdy_q[head.pr2] || (|hit2);

  always_comb begin
    out_d = '0;
    if (reset && nonempty) begin
      out_d.prd       = head.prd;
      out_d.pr1       = head.pr1;
      out_d.pr2       = head.pr2;
      out_d.pr1_ready = pr1_ready;
      out_d.pr2_ready = pr2_ready;
      out_d.imm       = head.imm;
      out_d.rob_index = rob_tail_q;
      out_d.opcode    = head.opcode;
      out_d.func3     = head.func3;
      out_d.func7     = head.func7;
    end
  end
  assign disp.dispatch_out = out_d;

  // Broadcast sets go first so a same-edge dispatch clear of that register wins.
  always_comb begin
    rdy_d = rdy_q;
    for (int i = 0; i < 3; i++) begin
      if (bc_vld[i]) rdy_d[bc_reg[i]] = 1'b1;
    end
    if (fire && head.has_rd && (head.prd != '0)) rdy_d[head.prd] = 1'b0;
    rdy_d[0] = 1'b1;
  end

  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    rob_tail_d = rob_tail_q;
    if (disp.flush) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      rob_tail_d = disp.rob_flush_tail;
    end else begin
      if (fire) begin
        head_d     = ptr_inc(head_q);
        rob_tail_d = (rob_tail_q == RW'(ROB_DEPTH - 1)) ? '0 : rob_tail_q + RW'(1);
      end
      if (enq) tail_d = ptr_inc(tail_q);
      case ({enq, fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      rob_tail_q <= '0;
      rdy_q      <= '1;
      ready_in_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      rob_tail_q <= rob_tail_d;
      rdy_q      <= rdy_d;
      ready_in_q <= (count_d < CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (enq) fifo_q[tail_q] <= entry_in;
  end

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed scenarios plus randomized traffic checked every cycle against a
// queue-based reference model of the dispatch unit.
module tb_dispatch_unit;
  import dispatch_unit_pkg::*;

  logic clk;
  logic reset;
  dispatch_unit_if bus();

  dispatch_unit dut (.clk(clk), .reset(reset), .disp(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [6:0]  prd, pr1, pr2;
    bit        has_rd, u1, u2;
    bit [31:0] imm;
    bit [6:0]  op;
    bit [2:0]  f3;
    bit [6:0]  f7;
  } instr_t;

  instr_t     mq[$];
  bit [127:0] mrdy;
  int         mrob;
  bit         mrdy_in;
  int         n_chk = 0;
  int         n_err = 0;
  bit [6:0]   ops [8];

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit src_rdy(input bit u, input bit [6:0] p);
    bit byp;
    byp = (bus.reg1_rdy_valid && bus.reg1_rdy == p) ||
          (bus.reg2_rdy_valid && bus.reg2_rdy == p) ||
          (bus.reg3_rdy_valid && bus.reg3_rdy == p);
    return !u || (p == 0) || mrdy[p] || byp;
  endfunction

  // One clock cycle: compare outputs with the model, advance the model, cross the edge.
  task automatic step();
    instr_t h, n;
    bit v, fire, mem, br;
    bit [2:0] expv;
    dispatch_pipeline_data exp_out;
    @(negedge clk);
    if (!reset) begin
      check_eq("rst_ready_in", bus.ready_in, 0);
      check_eq("rst_outputs", {bus.alu_valid, bus.br_valid, bus.mem_valid, bus.rob_alloc}, 0);
      check_eq("rst_payload", bus.dispatch_out, 0);
      mq.delete();
      mrdy = '1;
      mrob = 0;
      mrdy_in = 0;
    end else begin
      expv = 3'b000;
      fire = 0;
      v = (mq.size() > 0) && bus.rob_ready && !bus.flush;
      if (mq.size() > 0) begin
        h = mq[0];
        mem = (h.op == 7'h03) || (h.op == 7'h23);
        br  = (h.op == 7'h63) || (h.op == 7'h6F) || (h.op == 7'h67);
        if (v) expv = mem ? 3'b001 : (br ? 3'b010 : 3'b100);
        fire = (expv[2] && bus.alu_ready) || (expv[1] && bus.br_ready) || (expv[0] && bus.mem_ready);
        exp_out = '0;
        exp_out.prd = h.prd;
        exp_out.pr1 = h.pr1;
        exp_out.pr2 = h.pr2;
        exp_out.pr1_ready = src_rdy(h.u1, h.pr1);
        exp_out.pr2_ready = src_rdy(h.u2, h.pr2);
        exp_out.imm = h.imm;
        exp_out.rob_index = 4'(mrob);
        exp_out.opcode = h.op;
        exp_out.func3 = h.f3;
        exp_out.func7 = h.f7;
        check_eq("payload", bus.dispatch_out, exp_out);
      end
      check_eq("valids", {bus.alu_valid, bus.br_valid, bus.mem_valid}, expv);
      check_eq("rob_alloc", bus.rob_alloc, fire);
      check_eq("ready_in", bus.ready_in, mrdy_in);
      if (fire) $display("dispatch rob=%0d op=%h prd=%0d", mrob, h.op, h.prd);
      if (bus.reg1_rdy_valid) mrdy[bus.reg1_rdy] = 1;
      if (bus.reg2_rdy_valid) mrdy[bus.reg2_rdy] = 1;
      if (bus.reg3_rdy_valid) mrdy[bus.reg3_rdy] = 1;
      if (fire && h.has_rd && h.prd != 0) mrdy[h.prd] = 0;
      mrdy[0] = 1;
      if (bus.flush) begin
        mq.delete();
        mrob = int'(bus.rob_flush_tail);
      end else begin
        if (fire) begin
          mq.delete(0);
          mrob = (mrob + 1) % 16;
        end
        if (bus.valid_in && mrdy_in) begin
          n.prd = bus.in_prd;  n.pr1 = bus.in_pr1;  n.pr2 = bus.in_pr2;
          n.has_rd = bus.in_has_rd;  n.u1 = bus.in_uses_rs1;  n.u2 = bus.in_uses_rs2;
          n.imm = bus.in_imm;  n.op = bus.in_opcode;  n.f3 = bus.in_func3;  n.f7 = bus.in_func7;
          mq.push_back(n);
        end
      end
      mrdy_in = (mq.size() < 2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_in = 0;
    bus.rob_ready = 1;
    bus.alu_ready = 1;
    bus.br_ready = 1;
    bus.mem_ready = 1;
    bus.reg1_rdy_valid = 0;
    bus.reg2_rdy_valid = 0;
    bus.reg3_rdy_valid = 0;
    bus.flush = 0;
  endtask

  task automatic put(input logic [6:0] op, input logic [6:0] prd, input logic [6:0] pr1,
                     input logic [6:0] pr2, input logic hr, input logic u1, input logic u2);
    bus.valid_in = 1;
    bus.in_opcode = op;
    bus.in_prd = prd;
    bus.in_pr1 = pr1;
    bus.in_pr2 = pr2;
    bus.in_has_rd = hr;
    bus.in_uses_rs1 = u1;
    bus.in_uses_rs2 = u2;
    bus.in_imm = $urandom();
    bus.in_func3 = 3'($urandom_range(0, 7));
    bus.in_func7 = 7'($urandom_range(0, 127));
  endtask

  task automatic reset_pulse();
    reset = 0;
    step();
    reset = 1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fires;
    ops = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h37};
    idle();
    put(7'h33, 0, 0, 0, 0, 0, 0);
    bus.valid_in = 0;
    bus.rob_flush_tail = 0;
    bus.reg1_rdy = 0; bus.reg2_rdy = 0; bus.reg3_rdy = 0;
    mrdy = '1; mrob = 0; mrdy_in = 0;
    reset = 0;
    #1;
    repeat (3) step();

    // Basic ALU dispatch after reset
    reset = 1;
    step();
    #1;
    check_eq("s1_ready_in", bus.ready_in, 1);
    check_eq("s1_no_valid", {bus.alu_valid, bus.br_valid, bus.mem_valid}, 0);
    put(7'h33, 10, 1, 2, 1, 1, 1);
    step();
    bus.valid_in = 0;
    #1;
    check_eq("s1_alu_valid", bus.alu_valid, 1);
    check_eq("s1_pr1_ready", bus.dispatch_out.pr1_ready, 1);
    check_eq("s1_pr2_ready", bus.dispatch_out.pr2_ready, 1);
    check_eq("s1_rob_index", bus.dispatch_out.rob_index, 0);
    step();

    // Bypass from a same-cycle broadcast
    put(7'h33, 11, 10, 0, 1, 1, 0);
    step();
    bus.valid_in = 0;
    bus.reg2_rdy = 10;
    bus.reg2_rdy_valid = 1;
    #1;
    check_eq("s2_bypass", bus.dispatch_out.pr1_ready, 1);
    step();
    bus.reg2_rdy_valid = 0;
    put(7'h33, 10, 0, 0, 1, 0, 0);
    step();
    bus.valid_in = 0;
    step();
    put(7'h33, 12, 10, 0, 1, 1, 0);
    bus.alu_ready = 0;
    step();
    bus.valid_in = 0;
    #1;
    check_eq("s2_not_ready", bus.dispatch_out.pr1_ready, 0);
    step();
    bus.reg2_rdy = 10;
    bus.reg2_rdy_valid = 1;
    bus.alu_ready = 1;
    #1;
    check_eq("s2_late_bypass", bus.dispatch_out.pr1_ready, 1);
    step();
    bus.reg2_rdy_valid = 0;

    // Stalled memory head blocks a younger ALU op
    reset_pulse();
    bus.mem_ready = 0;
    put(7'h03, 5, 0, 0, 1, 0, 0);
    step();
    put(7'h33, 6, 0, 0, 1, 0, 0);
    step();
    bus.valid_in = 0;
    #1;
    check_eq("s3_mem_valid", bus.mem_valid, 1);
    check_eq("s3_ready_in_full", bus.ready_in, 0);
    check_eq("s3_alu_blocked", bus.alu_valid, 0);
    step();
    bus.mem_ready = 1;
    #1;
    check_eq("s3_mem_fire", bus.rob_alloc, 1);
    check_eq("s3_mem_rob", bus.dispatch_out.rob_index, 0);
    step();
    #1;
    check_eq("s3_alu_valid", bus.alu_valid, 1);
    check_eq("s3_alu_rob", bus.dispatch_out.rob_index, 1);
    step();

    // ROB index wrap over 17 dispatches
    reset_pulse();
    fires = 0;
    for (int cyc = 0; cyc < 60 && fires < 17; cyc++) begin
      put(7'h13, 7'($urandom_range(1, 15)), 0, 0, 0, 0, 0);
      #1;
      if (bus.alu_valid && bus.alu_ready) begin
        check_eq("s4_rob_seq", bus.dispatch_out.rob_index, 96'(fires % 16));
        fires++;
      end
      step();
    end
    bus.valid_in = 0;
    check_eq("s4_fire_count", fires, 17);
    put(7'h33, 3, 0, 0, 0, 0, 0);
    step();
    bus.valid_in = 0;
    bus.rob_ready = 0;
    #1;
    check_eq("s4_rob_full_valid", {bus.alu_valid, bus.br_valid, bus.mem_valid}, 0);
    check_eq("s4_rob_full_alloc", bus.rob_alloc, 0);
    step();
    bus.rob_ready = 1;
    repeat (3) step();

    // Flush with two buffered entries
    reset_pulse();
    bus.alu_ready = 0;
    put(7'h33, 7, 0, 0, 1, 0, 0);
    step();
    put(7'h13, 8, 0, 0, 1, 0, 0);
    step();
    bus.valid_in = 0;
    bus.flush = 1;
    bus.rob_flush_tail = 5;
    #1;
    check_eq("s5_flush_gate", {bus.alu_valid, bus.br_valid, bus.mem_valid}, 0);
    step();
    bus.flush = 0;
    bus.alu_ready = 1;
    #1;
    check_eq("s5_empty", bus.alu_valid, 0);
    check_eq("s5_ready_in", bus.ready_in, 1);
    put(7'h33, 9, 0, 0, 1, 0, 0);
    step();
    bus.valid_in = 0;
    #1;
    check_eq("s5_rob_index", bus.dispatch_out.rob_index, 5);
    step();

    // Dispatch clear beats a same-edge broadcast
    put(7'h33, 20, 0, 0, 1, 0, 0);
    step();
    bus.valid_in = 0;
    bus.reg1_rdy = 20;
    bus.reg1_rdy_valid = 1;
    step();
    bus.reg1_rdy_valid = 0;
    put(7'h33, 21, 0, 20, 1, 0, 1);
    step();
    bus.valid_in = 0;
    #1;
    check_eq("s6_clear_wins", bus.dispatch_out.pr2_ready, 0);
    step();

    // Randomized traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      reset = ($urandom_range(0, 199) != 0);
      put(ops[$urandom_range(0, 7)], 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
          7'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
      bus.valid_in = ($urandom_range(0, 9) < 6);
      bus.rob_ready = ($urandom_range(0, 9) < 8);
      bus.alu_ready = ($urandom_range(0, 9) < 7);
      bus.br_ready = ($urandom_range(0, 9) < 7);
      bus.mem_ready = ($urandom_range(0, 9) < 7);
      bus.reg1_rdy = 7'($urandom_range(0, 15));
      bus.reg2_rdy = 7'($urandom_range(0, 15));
      bus.reg3_rdy = 7'($urandom_range(0, 15));
      bus.reg1_rdy_valid = ($urandom_range(0, 9) < 3);
      bus.reg2_rdy_valid = ($urandom_range(0, 9) < 3);
      bus.reg3_rdy_valid = ($urandom_range(0, 9) < 3);
      bus.flush = ($urandom_range(0, 39) == 0);
      bus.rob_flush_tail = 4'($urandom_range(0, 15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
